muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit; sequential companion to the single-cycle ALU.
//  Executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU iteratively (one bit per cycle).
//  Results go to architectural HI/LO registers held inside the block.
//  Sits beside the ALU in EX. The pipeline stalls on Busy and reads HI/LO via MFHI/MFLO.
// PARAMETERS
//  W      32  operand width; HI and LO are each W bits (W >= 4, even)
//  CNT_W  $clog2(W+1)  iteration counter width (derived, not overridable)
// PORTS
//  Clock    in   1     single clock, rising edge
//  nReset   in   1     asynchronous, active-low reset
//  Start    in   1     request; sampled only when Busy==0
//  Func     in   6     operation code from shared package (MULT..MSUBU, MTHI, MTLO)
//  A        in   W     rs operand (dividend / multiplicand / MTHI-MTLO data)
//  B        in   W     rt operand (divisor / multiplier)
//  Flush    in   1     abort in-flight op (branch/exception); HI/LO untouched
//  Busy     out  1     op in progress; pipeline must stall HI/LO readers
//  Done     out  1     one-cycle pulse; HI/LO hold new values this cycle
//  DivZero  out  1     valid with Done; divisor was zero
//  Hi       out  W     HI register
//  Lo       out  W     LO register
// BEHAVIOUR
//  Reset (async, nReset=0): state IDLE, Hi=Lo=0, Busy=Done=DivZero=0. Counter and operand regs are cleared.
//  States: IDLE -> MUL|DIV -> FIX -> IDLE.
//  - IDLE + Start + mul-class Func: latch |A|,|B|, sign info, Func. Go to MUL, Busy=1 next cycle.
//  - IDLE + Start + DIV/DIVU: if B==0, go to FIX directly (no iterations). Otherwise go to DIV.
//  - MUL/DIV: exactly W iterations (shift-add / restoring subtract), counter W-1 down to 0. Then FIX.
//  - FIX: apply signs, accumulate. Write Hi/Lo on the exiting edge. Pulse Done, Busy=0, return to IDLE.
//  Latency from Start accepted to Done: W+2 cycles (W=32 -> 34). Div-by-zero: 2 cycles.
//  Back-to-back: Start may be asserted in the Done cycle and is accepted (Busy already 0).
//  Start while Busy=1: ignored; no queueing.
//  MTHI/MTLO: no Busy. Hi (or Lo) = A on the next edge. Done pulses that same cycle.
//  Signed ops (MULT, DIV, MADD, MSUB): iterate on magnitudes, correct in FIX.
//  - Product sign = A^B.
//  - Quotient sign = A^B; remainder sign = sign of A.
//  - Most-negative / -1: Lo = most-negative, Hi = 0. No flag.
//  Unsigned ops: zero-extended operands; no correction.
//  MULT/MULTU: {Hi,Lo} = 2W-bit product.
//  MADD(U): {Hi,Lo} += product, modulo 2^(2W).
//  MSUB(U): {Hi,Lo} -= product, modulo 2^(2W).
//  DIV/DIVU: Lo = quotient, Hi = remainder.
//  Divide by zero: Lo = all ones, Hi = A (raw), DivZero = 1 with Done. Applies to signed and unsigned.
//  Flush: any state -> IDLE next edge. Busy=0, no Done, Hi/Lo unchanged.
//  Flush + Start in the same cycle: Flush wins; Start is dropped.
//  Flush + FIX in the same cycle: Flush wins; no Hi/Lo write.
//  Reset mid-op: immediate IDLE, Hi=Lo=0.
//  Hi/Lo are never modified except on a Done edge.
//  Unknown Func with Start: treated as no-op; stays IDLE, no Done.
// STRUCTURE
//  Shared package (also used by the ALU): Func codes for MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
//  The package also holds the state enum (IDLE, MUL, DIV, FIX).
//  Sub-module muldiv_datapath: per-cycle shift-add / restoring-subtract step.
//  - Ports: partial-remainder/product registers in, next values out.
//  - Purely combinational, parameter W.
//  Top level holds the FSM, counter, sign fixup, accumulate, and Hi/Lo registers.
// TESTING (W=32)
//  MULT A=-3 (FFFFFFFD) B=7 -> Done at cycle 34; Hi=FFFFFFFF Lo=FFFFFFEB.
//  MULTU A=FFFFFFFF B=FFFFFFFF -> Hi=FFFFFFFE Lo=00000001.
//  DIV A=-7 B=2 -> Lo=FFFFFFFD Hi=FFFFFFFF.
//  DIV A=80000000 B=FFFFFFFF -> Lo=80000000 Hi=0.
//  DIVU A=5 B=0 -> Done after 2 cycles, DivZero=1, Lo=FFFFFFFF, Hi=5.
//  MTHI 0/MTLO 10, then MADD A=4 B=5 -> Lo=1E Hi=0.
//  Then MSUBU A=1 B=1F -> Lo=FFFFFFFF Hi=FFFFFFFF.
//  Start MULT, Flush at cycle 10 -> Busy drops next cycle, no Done, Hi/Lo unchanged.
//  Start MULT, deassert nReset at cycle 5 -> all outputs 0 asynchronously.
//  A new Start in the Done cycle is accepted.
//  Start pulsed while Busy -> ignored; result matches the first operands.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared multiply/divide definitions: Func codes (also decoded by the ALU) and
// the iterative unit's state encoding.
package muldiv_unit_pkg;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MADD  = 6'h1C;
    localparam logic [5:0] F_MADDU = 6'h1D;
    localparam logic [5:0] F_MSUB  = 6'h1E;
    localparam logic [5:0] F_MSUBU = 6'h1F;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    function automatic logic is_mul(input logic [5:0] f);
        return f inside {F_MULT, F_MULTU, F_MADD, F_MADDU, F_MSUB, F_MSUBU};
    endfunction

    function automatic logic is_div(input logic [5:0] f);
        return f inside {F_DIV, F_DIVU};
    endfunction

    function automatic logic is_signed(input logic [5:0] f);
        return f inside {F_MULT, F_DIV, F_MADD, F_MSUB};
    endfunction

endpackage

// File: rtl/muldiv_unit_datapath.sv
// One iteration of shift-add multiply or restoring divide on the {hi,lo}
// working pair; b is the multiplicand or divisor magnitude.
module muldiv_datapath #(
    parameter int W = 32
) (
    input  logic         is_div,
    input  logic [W-1:0] hi_in,
    input  logic [W-1:0] lo_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] hi_out,
    output logic [W-1:0] lo_out
);

    logic [W:0]   sum;
    logic [W-1:0] shifted_lo;
    logic [W-1:0] sub;
    logic         ge;

    always_comb begin
        sum        = {1'b0, hi_in} + (lo_in[0] ? {1'b0, b_in} : '0);
        shifted_lo = {hi_in[W-2:0], lo_in[W-1]};
        ge         = {hi_in, lo_in[W-1]} >= {1'b0, b_in};
        // the difference always fits in W bits when ge holds
        sub        = shifted_lo - b_in;
        if (is_div) begin
            hi_out = ge ? sub : shifted_lo;
            lo_out = {lo_in[W-2:0], ge};
        end else begin
            hi_out = sum[W:1];
            lo_out = {sum[0], lo_in[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO: FSM, iteration
// counter, sign fixup, accumulate and the HI/LO registers.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic         Start,
    input  logic [5:0]   Func,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Flush,
    output logic         Busy,
    output logic         Done,
    output logic         DivZero,
    output logic [W-1:0] Hi,
    output logic [W-1:0] Lo
);

    localparam int CNT_W = $clog2(W+1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     hi_r, lo_r, b_r, hi_step, lo_step;
    logic [5:0]       op;
    logic             sgn_p, sgn_r, dz;
    logic             load, step, wr, mt_hi, mt_lo;
    logic             neg_a, neg_b, b_zero;
    logic [W-1:0]     a_abs, b_abs;
    logic [2*W-1:0]   prod, prod_s, res;

    assign neg_a  = is_signed(Func) & A[W-1];
    assign neg_b  = is_signed(Func) & B[W-1];
    assign a_abs  = neg_a ? -A : A;
    assign b_abs  = neg_b ? -B : B;
    assign b_zero = (B == '0);
    assign Busy   = (state != IDLE);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        wr        = 1'b0;
        mt_hi     = 1'b0;
        mt_lo     = 1'b0;
        if (Flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    if (is_mul(Func)) begin
                        load      = 1'b1;
                        state_nxt = MUL;
                    end else if (is_div(Func)) begin
                        load      = 1'b1;
                        state_nxt = b_zero ? FIX : DIV;
                    end else if (Func == F_MTHI) begin
                        mt_hi = 1'b1;
                    end else if (Func == F_MTLO) begin
                        mt_lo = 1'b1;
                    end
                end
                MUL, DIV: begin
                    step = 1'b1;
                    if (cnt == '0) state_nxt = FIX;
                end
                FIX: begin
                    wr        = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    muldiv_datapath #(.W(W)) u_dp (
        .is_div (state == DIV),
        .hi_in  (hi_r),
        .lo_in  (lo_r),
        .b_in   (b_r),
        .hi_out (hi_step),
        .lo_out (lo_step)
    );

    // A divide by zero parks the raw dividend in hi_r for the FIX write
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
            b_r   <= '0;
            op    <= '0;
            sgn_p <= 1'b0;
            sgn_r <= 1'b0;
            dz    <= 1'b0;
        end else if (load) begin
            cnt   <= CNT_W'(W-1);
            hi_r  <= (is_div(Func) && b_zero) ? A : '0;
            lo_r  <= a_abs;
            b_r   <= b_abs;
            op    <= Func;
            sgn_p <= neg_a ^ neg_b;
            sgn_r <= neg_a;
            dz    <= is_div(Func) && b_zero;
        end else if (step) begin
            hi_r <= hi_step;
            lo_r <= lo_step;
            cnt  <= cnt - 1'b1;
        end
    end

    always_comb begin
        prod   = {hi_r, lo_r};
        prod_s = sgn_p ? -prod : prod;
        res    = prod_s;
        case (op)
            F_MADD, F_MADDU: res = {Hi, Lo} + prod_s;
            F_MSUB, F_MSUBU: res = {Hi, Lo} - prod_s;
            F_DIV, F_DIVU:   res = dz ? {hi_r, {W{1'b1}}}
                                      : {(sgn_r ? -hi_r : hi_r), (sgn_p ? -lo_r : lo_r)};
            default:         res = prod_s;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Hi      <= '0;
            Lo      <= '0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            Done    <= wr | mt_hi | mt_lo;
            DivZero <= wr & dz;
            if (wr)         {Hi, Lo} <= res;
            else if (mt_hi) Hi <= A;
            else if (mt_lo) Lo <= A;
        end
    end

endmodule
